// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front end: output format codes,
// byte-phase state type and pixel format conversion helpers.
package cam_pkg;

    localparam logic [1:0] MODE_RGB332 = 2'd0;
    localparam logic [1:0] MODE_RGB565 = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;

    typedef enum logic {PH_LO, PH_HI} phase_t;

    function automatic logic [7:0] rgb565_to_332(input logic [15:0] p);
        return {p[15:13], p[10:8], p[4:3]};
    endfunction

    // Mode 3 is an alias of RGB332, so it falls through to the default arm.
    function automatic logic [15:0] convert_pixel(input logic [1:0] mode, input logic [15:0] p);
        logic [15:0] r;
        case (mode)
            MODE_RGB565: r = p;
            MODE_GRAY:   r = {8'h00, p[7:0]};
            default:     r = {8'h00, rgb565_to_332(p)};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the camera sync lines and produces VSYNC-rise / HREF-fall pulses
// relative to the previous sample.
module cam_sync_edge (
    input  logic CLK,
    input  logic RES,
    input  logic HREF,
    input  logic VSYNC,
    output logic vs_rise,
    output logic href_fall
);

    logic last_vsync;
    logic last_href;

    always_ff @(posedge CLK) begin
        if (RES) begin
            last_vsync <= 1'b0;
            last_href  <= 1'b0;
        end else begin
            last_vsync <= VSYNC;
            last_href  <= HREF;
        end
    end

    assign vs_rise   = VSYNC & ~last_vsync;
    assign href_fall = last_href & ~HREF;

endmodule

// File: rtl/cam_pixel_decimator.sv
// Camera byte-pair assembler with format conversion and X/Y decimation.
// Optional line/frame length checking is enabled by defining CAM_LINE_CHECK_EN.
module cam_pixel_decimator
    import cam_pkg::*;
#(
    parameter int X_W     = 15,
    parameter int DECIM_X = 1,
    parameter int DECIM_Y = 1,
    parameter int EXP_W   = 176,
    parameter int EXP_H   = 144
) (
    input  logic           CLK,
    input  logic           RES,
    input  logic [7:0]     D,
    input  logic           HREF,
    input  logic           VSYNC,
    input  logic [1:0]     MODE,
    output logic [15:0]    PIXEL,
    output logic           SAMP_RDY,
    output logic           SOF,
    output logic [X_W-1:0] x_out,
    output logic [X_W-1:0] y_out,
    output logic [7:0]     FRAME_CNT,
    output logic           LINE_ERR,
    output logic           FRAME_ERR
);

    localparam int SHX = $clog2(DECIM_X);
    localparam int SHY = $clog2(DECIM_Y);
    localparam logic [X_W-1:0] AXIS_MAX = '1;
    localparam logic [X_W-1:0] MASK_X   = X_W'(DECIM_X - 1);
    localparam logic [X_W-1:0] MASK_Y   = X_W'(DECIM_Y - 1);

    if (DECIM_X < 1 || DECIM_X > 8 || (DECIM_X & (DECIM_X - 1)) != 0 ||
        DECIM_Y < 1 || DECIM_Y > 8 || (DECIM_Y & (DECIM_Y - 1)) != 0 ||
        EXP_W < 1 || EXP_H < 1) begin : g_bad_param
        $error("cam_pixel_decimator: illegal parameter value");
    end

    logic           vs_rise;
    logic           href_fall;
    phase_t         phase;
    logic [7:0]     lo_q;
    logic [1:0]     mode_q;
    logic           armed;
    logic           sof_pend;
    logic           line_seen;
    logic           y_sat;
    logic [X_W-1:0] raw_x;
    logic [X_W-1:0] raw_y;
    logic           keep;

    cam_sync_edge u_sync (
        .CLK       (CLK),
        .RES       (RES),
        .HREF      (HREF),
        .VSYNC     (VSYNC),
        .vs_rise   (vs_rise),
        .href_fall (href_fall)
    );

    // A pixel on a saturated axis is dropped rather than aliased onto the last index.
    assign keep = ((raw_x & MASK_X) == '0) && ((raw_y & MASK_Y) == '0) &&
                  (raw_x != AXIS_MAX) && !y_sat;

    always_ff @(posedge CLK) begin
        if (RES) begin
            phase     <= PH_LO;
            lo_q      <= 8'h00;
            mode_q    <= MODE_RGB332;
            armed     <= 1'b0;
            sof_pend  <= 1'b0;
            line_seen <= 1'b0;
            y_sat     <= 1'b0;
            raw_x     <= '0;
            raw_y     <= '0;
            PIXEL     <= 16'h0000;
            SAMP_RDY  <= 1'b0;
            SOF       <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            FRAME_CNT <= 8'h00;
        end else begin
            SAMP_RDY <= 1'b0;
            SOF      <= 1'b0;
            if (vs_rise) begin
                if (line_seen) FRAME_CNT <= FRAME_CNT + 8'd1;
                raw_x     <= '0;
                raw_y     <= '0;
                phase     <= PH_LO;
                mode_q    <= MODE;
                armed     <= 1'b1;
                sof_pend  <= 1'b1;
                line_seen <= 1'b0;
                y_sat     <= 1'b0;
            end else if (href_fall) begin
                if (armed) begin
                    line_seen <= 1'b1;
                    if (raw_y == AXIS_MAX) y_sat <= 1'b1;
                    else                   raw_y <= raw_y + 1'b1;
                end
                raw_x <= '0;
                phase <= PH_LO;
            end else if (HREF && armed && !VSYNC) begin
                case (phase)
                    PH_LO: begin
                        lo_q  <= D;
                        phase <= PH_HI;
                    end
                    PH_HI: begin
                        phase <= PH_LO;
                        if (raw_x != AXIS_MAX) raw_x <= raw_x + 1'b1;
                        if (keep) begin
                            PIXEL    <= convert_pixel(mode_q, {D, lo_q});
                            x_out    <= raw_x >> SHX;
                            y_out    <= raw_y >> SHY;
                            SAMP_RDY <= 1'b1;
                            SOF      <= sof_pend;
                            sof_pend <= 1'b0;
                        end
                    end
                    default: phase <= PH_LO;
                endcase
            end
        end
    end

`ifdef CAM_LINE_CHECK_EN
    localparam logic [X_W-1:0] EXP_W_V = X_W'(EXP_W);
    localparam logic [X_W-1:0] EXP_H_V = X_W'(EXP_H);

    // Checks mirror the counter priority: a VSYNC rise masks a coincident HREF fall.
    always_ff @(posedge CLK) begin
        if (RES) begin
            LINE_ERR  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else if (vs_rise) begin
            if (armed && raw_y != EXP_H_V) FRAME_ERR <= 1'b1;
        end else if (href_fall && armed && raw_x != EXP_W_V) begin
            LINE_ERR <= 1'b1;
        end
    end
`else
    assign LINE_ERR  = 1'b0;
    assign FRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cam_pixel_decimator.sv
// Directed bench: one DUT without decimation and one decimating 2x2, fed the same pins.
module tb_cam_pixel_decimator;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [7:0]  d = 8'h00;
    logic        href = 1'b0;
    logic        vsync = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic [15:0] pix_a, pix_b;
    logic        rdy_a, rdy_b, sof_a, sof_b;
    logic [14:0] x_a, y_a, x_b, y_b;
    logic [7:0]  fcnt_a, fcnt_b;
    logic        lerr_a, lerr_b, ferr_a, ferr_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] pix_q[$];
    logic [14:0] xa_q[$];
    logic [14:0] ya_q[$];
    logic        sof_q[$];
    logic [14:0] xb_q[$];
    logic [14:0] yb_q[$];

`ifdef CAM_LINE_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    cam_pixel_decimator #(.X_W(15), .DECIM_X(1), .DECIM_Y(1), .EXP_W(4), .EXP_H(4)) dut_a (
        .CLK(clk), .RES(res), .D(d), .HREF(href), .VSYNC(vsync), .MODE(mode),
        .PIXEL(pix_a), .SAMP_RDY(rdy_a), .SOF(sof_a), .x_out(x_a), .y_out(y_a),
        .FRAME_CNT(fcnt_a), .LINE_ERR(lerr_a), .FRAME_ERR(ferr_a)
    );

    cam_pixel_decimator #(.X_W(15), .DECIM_X(2), .DECIM_Y(2), .EXP_W(4), .EXP_H(4)) dut_b (
        .CLK(clk), .RES(res), .D(d), .HREF(href), .VSYNC(vsync), .MODE(mode),
        .PIXEL(pix_b), .SAMP_RDY(rdy_b), .SOF(sof_b), .x_out(x_b), .y_out(y_b),
        .FRAME_CNT(fcnt_b), .LINE_ERR(lerr_b), .FRAME_ERR(ferr_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy_a) begin
            pix_q.push_back(pix_a);
            xa_q.push_back(x_a);
            ya_q.push_back(y_a);
            sof_q.push_back(sof_a);
        end
        if (rdy_b) begin
            xb_q.push_back(x_b);
            yb_q.push_back(y_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_q();
        pix_q.delete(); xa_q.delete(); ya_q.delete(); sof_q.delete();
        xb_q.delete(); yb_q.delete();
    endtask

    task automatic byte_in(input logic [7:0] b);
        href = 1'b1;
        d = b;
        @(negedge clk);
    endtask

    task automatic px(input logic [7:0] lo, input logic [7:0] hi);
        byte_in(lo);
        byte_in(hi);
    endtask

    task automatic href_end();
        href = 1'b0;
        d = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        href = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic line_px(input int n);
        for (int i = 0; i < n; i++) px(8'(i), 8'(i + 1));
        href_end();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(rdy_a), 0);
        check("rst_pixel", 32'(pix_a), 0);
        check("rst_fcnt", 32'(fcnt_a), 0);
        check("rst_xy", {x_a, 1'b0, y_a}, 0);
        check("rst_sof", 32'(sof_a), 0);
        check("rst_lerr", 32'(lerr_a), 0);
        res = 1'b0;
        @(negedge clk);

        // Bytes before the first VSYNC are ignored
        px(8'h1F, 8'hE7); px(8'h1F, 8'hE7);
        href_end();
        check("pre_vsync_strobes", pix_q.size(), 0);

        // RGB332 line: 0x1F,0xE7 -> 0x00FF
        mode = 2'd0;
        vsync_pulse();
        check("first_frame_fcnt", 32'(fcnt_a), 0);
        for (int i = 0; i < 4; i++) px(8'h1F, 8'hE7);
        href_end();
        check("s1_count", pix_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("s1_pixel", 32'(pix_q[i]), 32'h00FF);
            check("s1_x", 32'(xa_q[i]), i);
            check("s1_y", 32'(ya_q[i]), 0);
            check("s1_sof", 32'(sof_q[i]), (i == 0) ? 1 : 0);
        end
        clear_q();

        // MODE change mid-frame keeps RGB332 until next VSYNC: 0x34,0x12 -> 0x0A
        mode = 2'd1;
        px(8'h34, 8'h12);
        href_end();
        check("midframe_count", pix_q.size(), 1);
        check("midframe_pixel", 32'(pix_q[0]), 32'h000A);
        check("midframe_y", 32'(ya_q[0]), 1);
        check("midframe_sof", 32'(sof_q[0]), 0);
        clear_q();

        vsync_pulse();
        check("fcnt_1", 32'(fcnt_a), 1);
        px(8'h34, 8'h12);
        href_end();
        check("rgb565_pixel", 32'(pix_q[0]), 32'h1234);
        check("rgb565_sof", 32'(sof_q[0]), 1);
        clear_q();

        mode = 2'd2;
        vsync_pulse();
        check("fcnt_2", 32'(fcnt_a), 2);
        px(8'h34, 8'h12);
        href_end();
        check("gray_pixel", 32'(pix_q[0]), 32'h0034);
        clear_q();

        // Odd byte count: 5 bytes -> 2 pixels, trailing byte dropped
        byte_in(8'h01); byte_in(8'h02); byte_in(8'h03); byte_in(8'h04); byte_in(8'h05);
        href_end();
        check("odd_count", pix_q.size(), 2);
        check("odd_p0", 32'(pix_q[0]), 32'h0001);
        check("odd_p1", 32'(pix_q[1]), 32'h0003);
        check("odd_x1", 32'(xa_q[1]), 1);
        check("odd_y", 32'(ya_q[1]), 1);
        clear_q();
        px(8'h07, 8'h08);
        href_end();
        check("after_odd_pixel", 32'(pix_q[0]), 32'h0007);
        check("after_odd_xy", {xa_q[0], 1'b0, ya_q[0]}, 32'd2);
        clear_q();

        // VSYNC rise coincident with HREF fall
        px(8'h55, 8'h66);
        href = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        check("coinc_fcnt", 32'(fcnt_a), 3);
        px(8'h11, 8'h22);
        href_end();
        check("coinc_count", pix_q.size(), 2);
        check("coinc_prev_y", 32'(ya_q[0]), 3);
        check("coinc_pixel", 32'(pix_q[1]), 32'h0011);
        check("coinc_xy", {xa_q[1], 1'b0, ya_q[1]}, 0);
        check("coinc_sof", 32'(sof_q[1]), 1);
        clear_q();

        // 2x2 decimation: 4 lines x 8 px
        vsync_pulse();
        check("fcnt_4", 32'(fcnt_a), 4);
        for (int l = 0; l < 4; l++) line_px(8);
        check("dec_a_count", pix_q.size(), 32);
        check("dec_b_count", xb_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("dec_b_x", 32'(xb_q[i]), i % 4);
            check("dec_b_y", 32'(yb_q[i]), i / 4);
        end
        clear_q();

        // Reset mid-line discards the partial frame
        byte_in(8'h01); byte_in(8'h02); byte_in(8'h03);
        res = 1'b1;
        byte_in(8'h04);
        check("res_rdy", 32'(rdy_a), 0);
        byte_in(8'h05);
        res = 1'b0;
        byte_in(8'h06); byte_in(8'h07); byte_in(8'h08); byte_in(8'h09);
        href_end();
        check("res_strobes", pix_q.size(), 1);
        check("res_fcnt", 32'(fcnt_a), 0);
        clear_q();

        // Line length checking
        vsync_pulse();
        check("post_res_fcnt", 32'(fcnt_a), 0);
        line_px(4);
        check("good_line_lerr", 32'(lerr_a), 0);
        check("good_line_strobes", pix_q.size(), 4);
        line_px(3);
        check("short_line_lerr", 32'(lerr_a), 32'(ERR_EXP));
        vsync_pulse();
        check("short_frame_ferr", 32'(ferr_a), 32'(ERR_EXP));
        check("fcnt_after_res", 32'(fcnt_a), 1);
        line_px(4);
        check("sticky_lerr", 32'(lerr_a), 32'(ERR_EXP));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
